f8_alu_multi: RTL and testbench

- Multi-byte sequential successor to the 8-bit F8 3850 ALU.
- Executes one F8 arithmetic/logic op on BYTES-wide operands, one byte per clock, LSB first, chaining carry between bytes.
- Sits beside the 8-bit ALU for DC0/wide-register arithmetic; start/busy/done handshake.
- Flags follow F8 semantics over the whole word.

---
 rtl/f8_alu_pkg.sv | 50 +++++
 rtl/f8_alu_byte_slice.sv | 77 +++++++
 rtl/f8_alu_multi.sv | 141 ++++++++++++++
 tb/tb_f8_alu_multi.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/f8_alu_pkg.sv
// f8_alu_pkg
// Definitions shared by the multi-byte F8 ALU and its byte slice.
//   op_e      : 4-bit op code, same values as the 8-bit ALU op macros
//   state_e   : sequencer state (IDLE / RUN / DONE)
//   flags_t   : F8 status flags {c, z, ov, s}
//   BCD_ADJ   : nibble correction applied by decimal add
//   init_carry: carry into byte 0 for a given op
package f8_alu_pkg;

   typedef enum logic [3:0] {
      OP_L       = 4'h0,
      OP_R       = 4'h1,
      OP_COM     = 4'h2,
      OP_AND     = 4'h3,
      OP_OR      = 4'h4,
      OP_XOR     = 4'h5,
      OP_ADD     = 4'h6,
      OP_INC     = 4'h7,
      OP_LINK    = 4'h8,
      OP_CMP     = 4'h9,
      OP_SL_1    = 4'hA,
      OP_ADD_BCD = 4'hB
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic c;
      logic z;
      logic ov;
      logic s;
   } flags_t;

   localparam logic [3:0] BCD_ADJ = 4'hA;

   // INC and CMP (two's complement of left) inject a 1, LINK injects c_in,
   // everything else (including SL_1's shifted-in bit) starts with 0.
   function automatic logic init_carry(op_e op, logic link_c);
      case (op)
         OP_LINK:         return link_c;
         OP_INC, OP_CMP:  return 1'b1;
         default:         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/f8_alu_byte_slice.sv
// f8_alu_byte_slice
// Combinational 8-bit F8 ALU operation on one byte of a wider word.
//   op           : operation
//   l, r         : left / right operand byte
//   cin          : carry in (also the bit shifted in by SL_1)
//   res          : result byte
//   cout         : carry out of bit 7 (bit 7 of l for SL_1)
//   c_into_b7    : carry into bit 7, for overflow
//   nibble_carry : carry out of bit 3
// Decimal adjust of ADD_BCD is built only with F8_ALU_MULTI_BCD_EN defined;
// otherwise ADD_BCD is a plain binary add.
module f8_alu_byte_slice
   import f8_alu_pkg::*;
(
   input  op_e        op,
   input  logic [7:0] l,
   input  logic [7:0] r,
   input  logic       cin,
   output logic [7:0] res,
   output logic       cout,
   output logic       c_into_b7,
   output logic       nibble_carry
);

   logic [7:0] a;
   logic [7:0] b;
   logic [8:0] sum9;
   logic       arith;

   always_comb begin
      a            = l;
      b            = r;
      arith        = 1'b0;
      res          = l;
      cout         = 1'b0;
      c_into_b7    = 1'b0;
      nibble_carry = 1'b0;
      case (op)
         OP_R:               res = r;
         OP_COM:             res = ~l;
         OP_AND:             res = l & r;
         OP_OR:              res = l | r;
         OP_XOR:             res = l ^ r;
         OP_ADD, OP_ADD_BCD: arith = 1'b1;
         OP_INC, OP_LINK: begin
            arith = 1'b1;
            b     = '0;
         end
         OP_CMP: begin
            arith = 1'b1;
            a     = r;
            b     = ~l;
         end
         OP_SL_1: begin
            res  = {l[6:0], cin};
            cout = l[7];
         end
         default:            res = l;
      endcase

      sum9 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      if (arith) begin
         res          = sum9[7:0];
         cout         = sum9[8];
         // carry into a bit position = sum bit XOR both operand bits
         c_into_b7    = sum9[7] ^ a[7] ^ b[7];
         nibble_carry = sum9[4] ^ a[4] ^ b[4];
`ifdef F8_ALU_MULTI_BCD_EN
         if (op == OP_ADD_BCD) begin
            if (!cout)         res[7:4] = res[7:4] + BCD_ADJ;
            if (!nibble_carry) res[3:0] = res[3:0] + BCD_ADJ;
         end
`endif
      end
   end

endmodule

// File: rtl/f8_alu_multi.sv
// f8_alu_multi
// Multi-byte F8 ALU: one op over BYTES bytes, one byte per clock, LSB first,
// carry chained between bytes. start/busy/done handshake.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : launch op (ignored while busy)
//   op, left, right,c_in: operation and operands, latched on accepted start
//   busy, done          : op in progress / one-cycle completion pulse
//   result              : result word, held until overwritten by next op
//   c, z, ov, s         : F8 flags over the whole word (s = 1 means positive)
// Build option: F8_ALU_MULTI_BCD_EN enables decimal adjust of ADD_BCD.
module f8_alu_multi
   import f8_alu_pkg::*;
#(
   parameter int unsigned BYTES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           op,
   input  logic [8*BYTES-1:0]   left,
   input  logic [8*BYTES-1:0]   right,
   input  logic                 c_in,
   output logic                 busy,
   output logic                 done,
   output logic [8*BYTES-1:0]   result,
   output logic                 c,
   output logic                 z,
   output logic                 ov,
   output logic                 s
);

   localparam int unsigned W  = 8 * BYTES;
   localparam int unsigned IW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

   state_e         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [W-1:0]   left_q, right_q;
   op_e            op_q;
   logic           cin_q;
   logic           carry_q, carry_d;
   logic [W-1:0]   result_q, result_d;
   flags_t         flags_q, flags_d;
   logic           latch;

   logic [7:0]     s_res;
   logic           s_cin, s_cout, s_c7;

   assign s_cin = (idx_q == '0) ? init_carry(op_q, cin_q) : carry_q;

   f8_alu_byte_slice u_slice (
      .op           (op_q),
      .l            (left_q [{idx_q, 3'b000} +: 8]),
      .r            (right_q[{idx_q, 3'b000} +: 8]),
      .cin          (s_cin),
      .res          (s_res),
      .cout         (s_cout),
      .c_into_b7    (s_c7),
      .nibble_carry ()
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      result_d = result_q;
      flags_d  = flags_q;
      latch    = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               latch   = 1'b1;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            result_d[{idx_q, 3'b000} +: 8] = s_res;
            carry_d = s_cout;
            if (idx_q == LAST) begin
               state_d    = ST_DONE;
               // flags see the completed word, including the byte written now
               flags_d.z  = (result_d == '0);
               flags_d.s  = ~result_d[W-1];
               flags_d.c  = 1'b0;
               flags_d.ov = 1'b0;
               if (op_q inside {OP_ADD, OP_INC, OP_LINK, OP_CMP, OP_ADD_BCD}) begin
                  flags_d.c  = s_cout;
                  flags_d.ov = s_c7 ^ s_cout;
               end
`ifdef F8_ALU_MULTI_BCD_EN
               if (op_q == OP_ADD_BCD) flags_d.ov = 1'b0;
`endif
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         left_q   <= '0;
         right_q  <= '0;
         op_q     <= OP_L;
         cin_q    <= 1'b0;
         carry_q  <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         if (latch) begin
            left_q  <= left;
            right_q <= right;
            op_q    <= op_e'(op);
            cin_q   <= c_in;
         end
      end
   end

   assign result = result_q;
   assign c      = flags_q.c;
   assign z      = flags_q.z;
   assign ov     = flags_q.ov;
   assign s      = flags_q.s;

endmodule

// File: tb/tb_f8_alu_multi.sv
module tb_f8_alu_multi;
   import f8_alu_pkg::*;

   localparam int unsigned BYTES = 2;
   localparam int unsigned W     = 8 * BYTES;

   typedef struct packed {
      logic [W-1:0] res;
      logic         c;
      logic         z;
      logic         ov;
      logic         s;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [3:0]    op = '0;
   logic [W-1:0]  left = '0;
   logic [W-1:0]  right = '0;
   logic          c_in = 1'b0;
   logic          busy, done;
   logic [W-1:0]  result;
   logic          c, z, ov, s;

   int unsigned   n_vec = 0;
   int unsigned   n_err = 0;
   int unsigned   n_done = 0;
   int unsigned   n_pushed = 0;
   exp_t          sb_q[$];

   f8_alu_multi #(.BYTES(BYTES)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .left   (left),
      .right  (right),
      .c_in   (c_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .c      (c),
      .z      (z),
      .ov     (ov),
      .s      (s)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         exp_t act;
         exp_t e;
         act = '{res: result, c: c, z: z, ov: ov, s: s};
         n_done++;
         n_vec++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done: got {res,c,z,ov,s}=%h, expected no done", act);
         end else begin
            e = sb_q.pop_front();
            if (act !== e) begin
               n_err++;
               $display("FAIL result: got {res,c,z,ov,s}=%h, expected %h", act, e);
            end
         end
      end
   end

   // Issue one op. Expected response goes to the scoreboard when push=1.
   // hammer=1 keeps start asserted with other operands until done is seen.
   task automatic issue(input string name, input logic [3:0] o, input logic [W-1:0] l,
                        input logic [W-1:0] r, input logic ci, input exp_t e,
                        input bit push, input bit hammer);
      int k;
      @(negedge clk);
      op = o; left = l; right = r; c_in = ci; start = 1'b1;
      if (push) begin
         sb_q.push_back(e);
         n_pushed++;
      end
      @(posedge clk);
      @(negedge clk);
      check({name, "_busy"}, 32'(busy), 32'd1);
      if (hammer) begin
         op = 4'(OP_ADD); left = 16'hffff; right = 16'hffff; c_in = 1'b1;
      end else begin
         start = 1'b0;
      end
      k = 1;
      while (!done && k < 10) begin
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check({name, "_latency"}, 32'(k), 32'(BYTES + 1));
   endtask

   function automatic exp_t mk(input logic [W-1:0] r, input logic c_, input logic z_,
                               input logic ov_, input logic s_);
      return '{res: r, c: c_, z: z_, ov: ov_, s: s_};
   endfunction

   initial begin
      exp_t none;
      int   k;
      none = '0;
      repeat (2) @(negedge clk);
      check("reset_state", {busy, done, result, c, z, ov, s}, '0);
      rst = 1'b0;

      issue("add",  4'(OP_ADD),  16'h7fff, 16'h0001, 1'b0, mk(16'h8000, 0, 0, 1, 0), 1, 0);
      issue("inc",  4'(OP_INC),  16'hffff, 16'h0000, 1'b0, mk(16'h0000, 1, 1, 0, 1), 1, 0);
      issue("cmpeq",4'(OP_CMP),  16'h1234, 16'h1234, 1'b0, mk(16'h0000, 1, 1, 0, 1), 1, 0);
      issue("cmplt",4'(OP_CMP),  16'h0001, 16'h0000, 1'b0, mk(16'hffff, 0, 0, 0, 0), 1, 0);
`ifdef F8_ALU_MULTI_BCD_EN
      issue("bcd",  4'(OP_ADD_BCD), 16'h1287, 16'h6667, 1'b0, mk(16'h1288, 0, 0, 0, 1), 1, 0);
`else
      issue("bcd",  4'(OP_ADD_BCD), 16'h1287, 16'h6667, 1'b0, mk(16'h78ee, 0, 0, 0, 1), 1, 0);
`endif
      issue("and",  4'(OP_AND),  16'hf0f0, 16'h3c3c, 1'b0, mk(16'h3030, 0, 0, 0, 1), 1, 0);
      issue("xor",  4'(OP_XOR),  16'haaaa, 16'haaaa, 1'b0, mk(16'h0000, 0, 1, 0, 1), 1, 0);
      issue("r",    4'(OP_R),    16'h1111, 16'h8001, 1'b0, mk(16'h8001, 0, 0, 0, 0), 1, 0);
      issue("com",  4'(OP_COM),  16'h00ff, 16'h0000, 1'b0, mk(16'hff00, 0, 0, 0, 0), 1, 0);
      issue("link", 4'(OP_LINK), 16'h00ff, 16'h0000, 1'b1, mk(16'h0100, 0, 0, 0, 1), 1, 0);
      issue("undef",4'hf,        16'h5555, 16'h9999, 1'b1, mk(16'h5555, 0, 0, 0, 1), 1, 0);
      issue("hammer",4'(OP_OR),  16'h1200, 16'h0034, 1'b0, mk(16'h1234, 0, 0, 0, 1), 1, 1);
      repeat (5) @(negedge clk);
      check("done_pulses", n_done, n_pushed);
      check("idle_after_hammer", 32'(busy), 32'd0);

      // Reset in the RUN cycle of byte 0 must clear everything at once.
      @(negedge clk);
      op = 4'(OP_ADD); left = 16'h1111; right = 16'h2222; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      rst = 1'b1;
      #1;
      check("async_reset", {busy, done, result, c, z, ov, s}, '0);
      @(negedge clk);
      rst = 1'b0;
      issue("sl1",  4'(OP_SL_1), 16'h4081, 16'h0000, 1'b0, mk(16'h8102, 0, 0, 0, 0), 1, 0);

      k = 0;
      while (sb_q.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 32'd0);
      check("done_total", n_done, n_pushed);
      if (none != '0) $display("unreachable");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
